hub75_scan_driver: RTL and testbench
====================================

HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

Interface
REQ-001 SHALL have parameter COLS, default 32, panel columns per row pair (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 4, row-address bits (2**ADDR_W row pairs).
REQ-003 SHALL have parameter BPC, default 4, bits per colour channel (bit planes).
REQ-004 SHALL have parameter BASE_T, default 8, plane-0 display time in clk cycles (>=1).
REQ-005 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  run scan when high.
REQ-008 SHALL have port swap_req  in  1  single-cycle pulse requesting front/back buffer swap.
REQ-009 SHALL have port swap_ack  out  1  single-cycle pulse when swap is performed.
REQ-010 SHALL have port rd_en  out  1  framebuffer read strobe.
REQ-011 SHALL have port rd_addr  out  1+ADDR_W+log2(COLS)  {front_buf, row, col}.
REQ-012 SHALL have port rd_data  in  6*BPC  {r1,g1,b1,r2,g2,b2}, each BPC bits, r1 at MSBs; valid cycle after rd_en.
REQ-013 SHALL have ports r1, g1, b1, r2, g2, b2  out  1 each  panel serial colour data.
REQ-014 SHALL have port row_addr  out  ADDR_W  panel row select (A,B,C,D... LSB=A).
REQ-015 SHALL have ports LAT, OEN, OCLK  out  1 each  latch, active-low output enable, shift clock.

Function
REQ-016 SHALL implement states IDLE, FETCH, LOAD, CLOCK, BLANK, LATCH, DISPLAY.
REQ-017 IDLE: OEN=1, rd_en=0; enable=1 -> FETCH with row=0, plane=0, col=0 next cycle.
REQ-018 FETCH (1 cycle): rd_en=1, rd_addr={front_buf,row,col}, OCLK=0.
REQ-019 LOAD (1 cycle): each colour output <= rd_data bit [plane] of its field; OCLK=0.
REQ-020 CLOCK (1 cycle): OCLK=1, colour outputs held; col==COLS-1 -> BLANK, else col+1 -> FETCH.
REQ-021 OEN SHALL be 1 in all states except DISPLAY; OCLK SHALL be 1 only in CLOCK.
REQ-022 BLANK (1 cycle): row_addr <= row; LAT=0.
REQ-023 LATCH (1 cycle): LAT=1; row_addr stable.
REQ-024 DISPLAY: OEN=0 for exactly BASE_T<<plane cycles, then advance.
REQ-025 Advance: plane<BPC-1 -> plane+1; else plane=0 and row+1 (wrap at 2**ADDR_W-1 -> 0 = frame end); col=0; -> FETCH.
REQ-026 Per-plane period SHALL be 3*COLS+2+(BASE_T<<plane) cycles; no idle cycles between planes.
REQ-027 swap_req SHALL set a pending flag; duplicate requests before frame end merge into one swap.
REQ-028 At frame end with pending set (incl. swap_req on that same cycle): toggle front_buf, swap_ack=1 one cycle, clear pending.
REQ-029 swap_req arriving the cycle after frame end SHALL wait for the next frame end.
REQ-030 enable SHALL be sampled only in IDLE and at frame end; enable=0 at frame end -> IDLE; deassertion mid-frame completes the frame.
REQ-031 rd_addr SHALL hold its last value when rd_en=0.

Reset
REQ-032 reset SHALL asynchronously force: state=IDLE, OEN=1, LAT=0, OCLK=0, rd_en=0, swap_ack=0, all colour outputs 0, row_addr=0, rd_addr=0, front_buf=0, pending=0, row=plane=col=0.
REQ-033 reset asserted mid-operation SHALL abort scan immediately; a pending swap SHALL be discarded.

Verification (COLS=4, ADDR_W=1, BPC=2, BASE_T=2 unless stated)
REQ-034 Reset then enable=1 -> 4 OCLK pulses, LAT pulse, OEN low 2 cycles (plane 0), then 4 OCLK, LAT, OEN low 4 cycles; frame = 68 cycles, repeats with no gap.
REQ-035 Memory model row0 col0 r1 field=2'b10 -> plane 0 shifts r1=0, plane 1 shifts r1=1 for first column; row_addr=0 then 1 at BLANK of row 1.
REQ-036 swap_req pulse at cycle 10 -> swap_ack exactly at frame end (cycle 67 rel. start), next frame rd_addr MSB=1; two pulses in one frame -> one toggle.
REQ-037 swap_req on frame-end cycle -> immediate swap; on following cycle -> swap at next frame end.
REQ-038 enable dropped mid-frame -> frame completes, IDLE with OEN=1; reset asserted during DISPLAY -> OEN=1 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/hub75_scan_driver.sv
// HUB75 LED panel scan driver.
// Fetches pixel pairs from a double-buffered framebuffer, shifts one bit plane
// per row pair out on the serial colour lines, latches it, then lights the row
// for a binary-weighted time (BASE_T << plane). Buffer swaps happen only at
// frame end so a frame is never shown half old, half new.
//
// Framebuffer handshake: rd_en is a one-cycle strobe with rd_addr valid in the
// same cycle; rd_data must be valid on the following cycle. There is no
// back-pressure. rd_addr holds its value while rd_en is low.
module hub75_scan_driver #(
  parameter int COLS   = 32,
  parameter int ADDR_W = 4,
  parameter int BPC    = 4,
  parameter int BASE_T = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic                          rd_en,
  output logic [ADDR_W+$clog2(COLS):0]  rd_addr,
  input  logic [6*BPC-1:0]              rd_data,
  output logic                          r1,
  output logic                          g1,
  output logic                          b1,
  output logic                          r2,
  output logic                          g2,
  output logic                          b2,
  output logic [ADDR_W-1:0]             row_addr,
  output logic                          LAT,
  output logic                          OEN,
  output logic                          OCLK,
  output logic [2:0]                    dbg_state
);

  localparam int COL_W    = $clog2(COLS);
  localparam int PL_W     = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DISP_MAX = BASE_T << (BPC - 1);
  localparam int CNT_W    = $clog2(DISP_MAX + 1);
  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_T);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    CLOCK   = 3'd3,
    BLANK   = 3'd4,
    LATCH   = 3'd5,
    DISPLAY = 3'd6
  } state_t;

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic [ADDR_W-1:0]   row_q;
  logic [PL_W-1:0]     plane_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                front_q;
  logic                pending_q;

  logic [BPC-1:0]      f_r1, f_g1, f_b1, f_r2, f_g2, f_b2;
  logic                last_plane, frame_end, do_swap;
  logic [PL_W-1:0]     plane_d;
  logic [ADDR_W-1:0]   row_d;

  // Field split of the read word and the plane/row advance decision.
  always_comb begin
    f_r1 = rd_data[6*BPC-1 -: BPC];
    f_g1 = rd_data[5*BPC-1 -: BPC];
    f_b1 = rd_data[4*BPC-1 -: BPC];
    f_r2 = rd_data[3*BPC-1 -: BPC];
    f_g2 = rd_data[2*BPC-1 -: BPC];
    f_b2 = rd_data[BPC-1:0];
    last_plane = (plane_q == PL_W'(BPC - 1));
    frame_end  = (state_q == DISPLAY) && (cnt_q == '0) && last_plane &&
                 (row_q == {ADDR_W{1'b1}});
    // A request arriving on the frame-end cycle itself is honoured immediately.
    do_swap    = frame_end && (pending_q || swap_req);
    plane_d    = last_plane ? '0 : plane_q + PL_W'(1);
    row_d      = last_plane ? row_q + ADDR_W'(1) : row_q;
  end

  // Ack must coincide with the frame-end cycle, so it is decoded, not registered.
  assign swap_ack  = do_swap;
  assign dbg_state = state_q;

  // Scan FSM with registered panel and framebuffer outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      plane_q   <= '0;
      cnt_q     <= '0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      r1 <= 1'b0; g1 <= 1'b0; b1 <= 1'b0;
      r2 <= 1'b0; g2 <= 1'b0; b2 <= 1'b0;
      row_addr  <= '0;
      LAT       <= 1'b0;
      OEN       <= 1'b1;
      OCLK      <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      LAT   <= 1'b0;
      OEN   <= 1'b1;
      OCLK  <= 1'b0;

      if (do_swap) begin
        pending_q <= 1'b0;
        front_q   <= ~front_q;
      end else if (swap_req) begin
        pending_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q <= FETCH;
            row_q   <= '0;
            plane_q <= '0;
            col_q   <= '0;
            rd_en   <= 1'b1;
            rd_addr <= {front_q, {ADDR_W{1'b0}}, {COL_W{1'b0}}};
          end
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          r1 <= f_r1[plane_q]; g1 <= f_g1[plane_q]; b1 <= f_b1[plane_q];
          r2 <= f_r2[plane_q]; g2 <= f_g2[plane_q]; b2 <= f_b2[plane_q];
          OCLK    <= 1'b1;
          state_q <= CLOCK;
        end
        CLOCK: begin
          if (col_q == COL_W'(COLS - 1)) begin
            state_q  <= BLANK;
            row_addr <= row_q;
          end else begin
            col_q   <= col_q + COL_W'(1);
            state_q <= FETCH;
            rd_en   <= 1'b1;
            rd_addr <= {front_q, row_q, col_q + COL_W'(1)};
          end
        end
        BLANK: begin
          LAT     <= 1'b1;
          state_q <= LATCH;
        end
        LATCH: begin
          OEN     <= 1'b0;
          cnt_q   <= (BASE_C << plane_q) - CNT_W'(1);
          state_q <= DISPLAY;
        end
        DISPLAY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            OEN   <= 1'b0;
          end else begin
            plane_q <= plane_d;
            row_q   <= row_d;
            col_q   <= '0;
            if (frame_end && !enable) begin
              state_q <= IDLE;
            end else begin
              state_q <= FETCH;
              rd_en   <= 1'b1;
              rd_addr <= {front_q ^ do_swap, row_d, {COL_W{1'b0}}};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver with COLS=4, ADDR_W=1, BPC=2, BASE_T=2.
// Cycle 0 is the first FETCH cycle after enable. Per-plane layout:
// col c FETCH/LOAD/CLOCK at 3c..3c+2, BLANK 12, LATCH 13, DISPLAY from 14.
// Plane starts: row0 p0=0, row0 p1=16, row1 p0=34, row1 p1=50; frame = 68.
module tb_hub75_scan_driver;

  localparam int COLS = 4, ADDR_W = 1, BPC = 2, BASE_T = 2;
  localparam int IDLE_ST = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        swap_req = 1'b0;
  logic        swap_ack, rd_en;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data = '0;
  logic        r1, g1, b1, r2, g2, b2;
  logic [0:0]  row_addr;
  logic        LAT, OEN, OCLK;
  logic [2:0]  dbg_state;

  logic [11:0] mem [16];
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  hub75_scan_driver #(.COLS(COLS), .ADDR_W(ADDR_W), .BPC(BPC), .BASE_T(BASE_T)) dut (
    .clk(clk), .reset(reset), .enable(enable), .swap_req(swap_req),
    .swap_ack(swap_ack), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_addr(row_addr), .LAT(LAT), .OEN(OEN), .OCLK(OCLK), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // framebuffer model: one-cycle read latency
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic start_scan();
    reset = 1'b1; enable = 1'b0; swap_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({OEN, LAT, OCLK, rd_en, swap_ack} !== 5'b10000) $display("FAIL reset_ctrl: got %b expected 10000", {OEN, LAT, OCLK, rd_en, swap_ack});
    else n_pass++;
    n_total++;
    if ({r1, g1, b1, r2, g2, b2, row_addr, rd_addr} !== 11'd0) $display("FAIL reset_data: got %h expected 0", {r1, g1, b1, r2, g2, b2, row_addr, rd_addr});
    else n_pass++;
    n_total++;
    if (dbg_state !== 3'(IDLE_ST)) $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE_ST);
    else n_pass++;
  endtask

  task automatic test_frame_timing();
    int oclk_n [2], lat_n [2], oen_n [2];
    oclk_n = '{0, 0}; lat_n = '{0, 0}; oen_n = '{0, 0};
    start_scan();
    while (cyc < 136) begin
      oclk_n[cyc / 68] += int'(OCLK);
      lat_n[cyc / 68]  += int'(LAT);
      oen_n[cyc / 68]  += int'(!OEN);
      if (cyc == 0 || cyc == 16 || cyc == 34 || cyc == 68) begin
        n_total++;
        if (rd_en !== 1'b1) $display("FAIL plane_start c%0d: rd_en=%b expected 1", cyc, rd_en);
        else n_pass++;
      end
      if (cyc == 2) begin
        n_total++;
        if (OCLK !== 1'b1) $display("FAIL first_oclk: got %b expected 1", OCLK);
        else n_pass++;
      end
      if (cyc == 13 || cyc == 29) begin
        n_total++;
        if (LAT !== 1'b1) $display("FAIL lat_pos c%0d: got %b expected 1", cyc, LAT);
        else n_pass++;
      end
      if (cyc == 13 || cyc == 16 || cyc == 29 || cyc == 34) begin
        n_total++;
        if (OEN !== 1'b1) $display("FAIL oen_off c%0d: got %b expected 1", cyc, OEN);
        else n_pass++;
      end
      if (cyc == 14 || cyc == 15 || cyc == 33) begin
        n_total++;
        if (OEN !== 1'b0) $display("FAIL oen_on c%0d: got %b expected 0", cyc, OEN);
        else n_pass++;
      end
      if (cyc == 4 || cyc == 12 || cyc == 34) begin
        n_total++;
        if (rd_addr !== ((cyc == 4) ? 4'd1 : (cyc == 12) ? 4'd3 : 4'd4))
          $display("FAIL rd_addr c%0d: got %h", cyc, rd_addr);
        else n_pass++;
      end
      if (cyc == 45 || cyc == 46) begin
        n_total++;
        if (row_addr !== ((cyc == 46) ? 1'b1 : 1'b0)) $display("FAIL row_addr c%0d: got %b", cyc, row_addr);
        else n_pass++;
      end
      step();
    end
    for (int f = 0; f < 2; f++) begin
      n_total++;
      if ({oclk_n[f], lat_n[f], oen_n[f]} !== {32'd16, 32'd4, 32'd12})
        $display("FAIL frame_counts f%0d: oclk=%0d lat=%0d oen_low=%0d expected 16 4 12", f, oclk_n[f], lat_n[f], oen_n[f]);
      else n_pass++;
    end
  endtask

  task automatic test_colour_data();
    start_scan();
    run_to(2);
    n_total++;
    if (r1 !== 1'b0) $display("FAIL r1_plane0: got %b expected 0", r1); else n_pass++;
    run_to(5);
    n_total++;
    if ({r1, g1, b1, r2, g2, b2} !== 6'b000001) $display("FAIL col1_plane0: got %b expected 000001", {r1, g1, b1, r2, g2, b2}); else n_pass++;
    run_to(11);
    n_total++;
    if ({r1, g1, b1, r2, g2, b2} !== 6'b111111) $display("FAIL col3_plane0: got %b expected 111111", {r1, g1, b1, r2, g2, b2}); else n_pass++;
    run_to(18);
    n_total++;
    if (r1 !== 1'b1) $display("FAIL r1_plane1: got %b expected 1", r1); else n_pass++;
    run_to(21);
    n_total++;
    if (b2 !== 1'b0) $display("FAIL b2_plane1: got %b expected 0", b2); else n_pass++;
    run_to(36);
    n_total++;
    if ({r1, g1, b1} !== 3'b010) $display("FAIL row1_g1: got %b expected 010", {r1, g1, b1}); else n_pass++;
  endtask

  task automatic test_swap();
    int acks;
    start_scan();
    acks = 0;
    while (cyc < 136) begin
      swap_req = (cyc == 10 || cyc == 80 || cyc == 100);
      #1;
      acks += int'(swap_ack);
      if (cyc == 67 || cyc == 135) begin
        n_total++;
        if (swap_ack !== 1'b1) $display("FAIL swap_ack_pos c%0d: got %b expected 1", cyc, swap_ack); else n_pass++;
      end
      if (cyc == 68) begin
        n_total++;
        if (rd_addr !== 4'h8) $display("FAIL swap_front: rd_addr=%h expected 8", rd_addr); else n_pass++;
      end
      if (cyc == 70) begin
        n_total++;
        if ({r1, g1, b1, r2, g2, b2} !== 6'b111111) $display("FAIL back_buf_data: got %b expected 111111", {r1, g1, b1, r2, g2, b2}); else n_pass++;
      end
      step();
    end
    swap_req = 1'b0;
    n_total++;
    if (acks !== 2) $display("FAIL swap_ack_count: got %0d expected 2", acks); else n_pass++;
    n_total++;
    if (rd_addr !== 4'h0) $display("FAIL merged_toggle: rd_addr=%h expected 0", rd_addr); else n_pass++;
  endtask

  task automatic test_swap_edge();
    int acks;
    start_scan();
    run_to(67);
    swap_req = 1'b1; #1;
    n_total++;
    if (swap_ack !== 1'b1) $display("FAIL same_cycle_ack: got %b expected 1", swap_ack); else n_pass++;
    step();
    n_total++;
    if (rd_addr[3] !== 1'b1) $display("FAIL same_cycle_front: got %b expected 1", rd_addr[3]); else n_pass++;
    acks = 0;
    while (cyc < 135) begin
      swap_req = (cyc == 68); #1;
      acks += int'(swap_ack);
      step();
    end
    n_total++;
    if (acks !== 0) $display("FAIL late_req_early_ack: got %0d acks expected 0", acks); else n_pass++;
    n_total++;
    if (swap_ack !== 1'b1) $display("FAIL late_req_ack: got %b expected 1", swap_ack); else n_pass++;
    step();
    n_total++;
    if (rd_addr[3] !== 1'b0) $display("FAIL late_req_front: got %b expected 0", rd_addr[3]); else n_pass++;
  endtask

  task automatic test_enable_drop();
    int busy;
    start_scan();
    run_to(20);
    enable = 1'b0;
    run_to(34);
    n_total++;
    if (rd_en !== 1'b1) $display("FAIL frame_continues: rd_en=%b expected 1", rd_en); else n_pass++;
    run_to(68);
    n_total++;
    if ({dbg_state, OEN, rd_en} !== {3'(IDLE_ST), 1'b1, 1'b0}) $display("FAIL drop_to_idle: state=%0d OEN=%b rd_en=%b expected 0 1 0", dbg_state, OEN, rd_en); else n_pass++;
    busy = 0;
    while (cyc < 78) begin
      busy += int'(OCLK) + int'(!OEN) + int'(rd_en);
      step();
    end
    n_total++;
    if (busy !== 0) $display("FAIL idle_quiet: got %0d active samples expected 0", busy); else n_pass++;
  endtask

  task automatic test_reset_display();
    int acks;
    start_scan();
    while (cyc < 14) begin
      swap_req = (cyc == 5);
      step();
    end
    swap_req = 1'b0;
    n_total++;
    if (OEN !== 1'b0) $display("FAIL pre_reset_oen: got %b expected 0", OEN); else n_pass++;
    reset = 1'b1; #1;
    n_total++;
    if ({OEN, LAT, OCLK, rd_en, swap_ack, dbg_state} !== {5'b10000, 3'(IDLE_ST)})
      $display("FAIL async_reset_ctrl: got %b", {OEN, LAT, OCLK, rd_en, swap_ack, dbg_state});
    else n_pass++;
    n_total++;
    if ({r1, g1, b1, r2, g2, b2, row_addr, rd_addr} !== 11'd0) $display("FAIL async_reset_data: got %h expected 0", {r1, g1, b1, r2, g2, b2, row_addr, rd_addr}); else n_pass++;
    start_scan();
    acks = 0;
    while (cyc < 68) begin
      acks += int'(swap_ack);
      step();
    end
    n_total++;
    if ({acks[3:0], rd_addr[3]} !== 5'd0) $display("FAIL pending_discarded: acks=%0d front=%b expected 0 0", acks, rd_addr[3]); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    mem[0] = 12'h800;  // row0 col0: r1 field 2'b10
    mem[1] = 12'h001;  // row0 col1: b2 field 2'b01
    mem[3] = 12'hFFF;  // row0 col3: all fields set
    mem[4] = 12'h300;  // row1 col0: g1 field 2'b11
    mem[8] = 12'hFFF;  // back buffer row0 col0
    test_reset();
    test_frame_timing();
    test_colour_data();
    test_swap();
    test_swap_edge();
    test_enable_drop();
    test_reset_display();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
